motor_cmd_sequencer: RTL and testbench

//  Sits in front of Motor: arbitrates signed power commands from manual and auto requesters and drives motorPower.

---
 rtl/motor_cmd_sequencer.sv | 158 +++++++++++++++
 tb/tb_motor_cmd_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_sequencer.sv
// Arbitrates signed manual/auto power commands and drives a rate-limited motor power output
// with dead time on every decay to zero, a command watchdog and an emergency stop.
module motor_cmd_sequencer #(
    parameter int SIZE          = 16,
    parameter int TICK_DIV      = 100000,
    parameter int RAMP_STEP     = 32,
    parameter int DEAD_TICKS    = 20,
    parameter int TIMEOUT_TICKS = 250,
    parameter int MAX_POWER     = 623
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            estop,
    input  logic            man_valid,
    input  logic [SIZE-1:0] man_power,
    input  logic            auto_valid,
    input  logic [SIZE-1:0] auto_power,
    output logic [SIZE-1:0] motorPower,
    output logic [1:0]      grant,
    output logic            busy,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DEAD  = 2'b01,
        ST_ESTOP = 2'b10
    } state_e;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEAD_TICKS + 1);
    localparam int WW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic signed [SIZE:0] MAX_P = (SIZE+1)'(MAX_POWER);
    localparam logic signed [SIZE:0] MIN_P = (SIZE+1)'(-MAX_POWER);
    localparam logic signed [SIZE:0] STEP  = (SIZE+1)'(RAMP_STEP);

    // Power and target are kept one bit wider so clamp/ramp arithmetic never overflows.
    state_e                 state_q, state_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [DW-1:0]          dead_cnt_q, dead_cnt_d;
    logic [WW-1:0]          wd_cnt_q, wd_cnt_d;
    logic signed [SIZE:0]   power_q, power_d;
    logic signed [SIZE:0]   target_q, target_d;
    logic [1:0]             grant_q, grant_d;

    logic                   tick, accept, timeout;
    logic signed [SIZE:0]   cmd_ext, cmd_clamped;
    logic signed [SIZE:0]   diff, abs_p, abs_d, ramp_next;

    assign tick    = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign accept  = !estop && (state_q != ST_ESTOP) && (man_valid || auto_valid);
    assign timeout = !accept && tick && (wd_cnt_q == WW'(TIMEOUT_TICKS - 1));

    always_comb begin
        cmd_ext = man_valid ? {man_power[SIZE-1], man_power} : {auto_power[SIZE-1], auto_power};
        if (cmd_ext > MAX_P)
            cmd_clamped = MAX_P;
        else if (cmd_ext < MIN_P)
            cmd_clamped = MIN_P;
        else
            cmd_clamped = cmd_ext;
    end

    // Opposite-signed target first drains to zero so a reversal always passes through DEAD.
    always_comb begin
        diff  = target_q - power_q;
        abs_p = power_q[SIZE] ? -power_q : power_q;
        abs_d = diff[SIZE] ? -diff : diff;
        if (power_q == target_q)
            ramp_next = power_q;
        else if (power_q != '0 && target_q != '0 && power_q[SIZE] != target_q[SIZE])
            ramp_next = (abs_p <= STEP) ? '0 : (power_q[SIZE] ? power_q + STEP : power_q - STEP);
        else
            ramp_next = (abs_d <= STEP) ? target_q : (diff[SIZE] ? power_q - STEP : power_q + STEP);
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        dead_cnt_d = dead_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        power_d    = power_q;
        target_d   = target_q;
        grant_d    = grant_q;

        if (accept)
            wd_cnt_d = '0;
        else if (tick && wd_cnt_q != WW'(TIMEOUT_TICKS))
            wd_cnt_d = wd_cnt_q + 1'b1;

        if (estop) begin
            power_d  = '0;
            target_d = '0;
            grant_d  = 2'b00;
            state_d  = ST_ESTOP;
        end else begin
            if (accept) begin
                target_d = cmd_clamped;
                grant_d  = man_valid ? 2'b10 : 2'b01;
            end else if (timeout) begin
                target_d = '0;
                grant_d  = 2'b00;
            end

            case (state_q)
                ST_RUN: begin
                    if (tick) begin
                        power_d = ramp_next;
                        if (power_q != '0 && ramp_next == '0) begin
                            state_d    = ST_DEAD;
                            dead_cnt_d = '0;
                        end
                    end
                end
                ST_DEAD: begin
                    if (tick) begin
                        if (dead_cnt_q == DW'(DEAD_TICKS - 1)) begin
                            state_d    = ST_RUN;
                            dead_cnt_d = '0;
                        end else begin
                            dead_cnt_d = dead_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            tick_cnt_q <= '0;
            dead_cnt_q <= '0;
            wd_cnt_q   <= '0;
            power_q    <= '0;
            target_q   <= '0;
            grant_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            power_q    <= power_d;
            target_q   <= target_d;
            grant_q    <= grant_d;
        end
    end

    assign motorPower = power_q[SIZE-1:0];
    assign grant      = grant_q;
    assign busy       = (power_q != target_q) || (state_q != ST_RUN);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench for motor_cmd_sequencer with a 4-cycle tick; after each reset release
// the ramp/dead/watchdog updates land on edges 4, 8, 12, ... counted from release.
module tb_motor_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        estop = 1'b0;
    logic        man_valid = 1'b0;
    logic [15:0] man_power = '0;
    logic        auto_valid = 1'b0;
    logic [15:0] auto_power = '0;
    logic [15:0] motor_power;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    motor_cmd_sequencer #(
        .SIZE(16), .TICK_DIV(4), .RAMP_STEP(32), .DEAD_TICKS(3),
        .TIMEOUT_TICKS(10), .MAX_POWER(623)
    ) dut (
        .clk(clk), .rst(rst), .estop(estop),
        .man_valid(man_valid), .man_power(man_power),
        .auto_valid(auto_valid), .auto_power(auto_power),
        .motorPower(motor_power), .grant(grant), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pwr(input string tag, input int exp);
        chk(tag, 32'($signed(motor_power)), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        estop = 1'b0;
        man_valid = 1'b0;
        auto_valid = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic send(input logic mv, input logic [15:0] mp, input logic av, input logic [15:0] ap);
        man_valid = mv;
        man_power = mp;
        auto_valid = av;
        auto_power = ap;
        cyc(1);
        man_valid = 1'b0;
        auto_valid = 1'b0;
    endtask

    initial begin
        // Reset state while rst is held
        cyc(2);
        chk_pwr("rst_power", 0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Ramp up to 100
        send(1'b0, 16'd0, 1'b1, 16'd100);
        chk("ramp_grant", 32'(grant), 32'd1);
        chk("ramp_busy0", 32'(busy), 32'd1);
        chk_pwr("ramp_p0", 0);
        cyc(3);  chk_pwr("ramp_p1", 32);
        cyc(4);  chk_pwr("ramp_p2", 64);
        cyc(4);  chk_pwr("ramp_p3", 96);
        chk("ramp_busy_mid", 32'(busy), 32'd1);
        cyc(4);  chk_pwr("ramp_p4", 100);
        chk("ramp_busy_done", 32'(busy), 32'd0);
        chk("ramp_state", 32'(state_dbg), 32'd0);

        // Reversal to -64 through dead time
        send(1'b0, 16'd0, 1'b1, 16'hFFC0);
        cyc(3);  chk_pwr("rev_p1", 68);
        cyc(4);  chk_pwr("rev_p2", 36);
        cyc(4);  chk_pwr("rev_p3", 4);
        cyc(4);  chk_pwr("rev_zero", 0);
        chk("rev_dead_enter", 32'(state_dbg), 32'd1);
        cyc(4);  chk("rev_dead_t1", 32'(state_dbg), 32'd1);
        cyc(4);  chk("rev_dead_t2", 32'(state_dbg), 32'd1);
        cyc(4);  chk("rev_run", 32'(state_dbg), 32'd0);
        chk_pwr("rev_run_p", 0);
        cyc(4);  chk_pwr("rev_n1", -32);
        cyc(4);  chk_pwr("rev_n2", -64);
        chk("rev_busy", 32'(busy), 32'd0);
        chk("rev_grant", 32'(grant), 32'd1);

        // Manual beats auto; +1000 clamps to 623
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            send(1'b1, 16'd1000, 1'b1, 16'hFF38);
            if (k == 1) chk("prio_grant", 32'(grant), 32'd2);
            cyc(3);
            chk_pwr($sformatf("clamp_pos_%0d", k), (32 * k > 623) ? 623 : 32 * k);
        end
        chk("clamp_pos_busy", 32'(busy), 32'd0);
        chk("clamp_pos_grant", 32'(grant), 32'd2);

        // -32768 clamps to -623
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            send(1'b1, 16'h8000, 1'b1, 16'd200);
            cyc(3);
            chk_pwr($sformatf("clamp_neg_%0d", k), (32 * k > 623) ? -623 : -32 * k);
        end
        chk("clamp_neg_busy", 32'(busy), 32'd0);

        // Watchdog: 10 ticks after the last accept the target drops to 0
        do_reset();
        send(1'b0, 16'd0, 1'b1, 16'd64);
        chk("wd_grant0", 32'(grant), 32'd1);
        cyc(3);  chk_pwr("wd_p1", 32);
        cyc(4);  chk_pwr("wd_p2", 64);
        cyc(31); chk("wd_grant_before", 32'(grant), 32'd1);
        cyc(1);  chk("wd_grant_after", 32'(grant), 32'd0);
        chk_pwr("wd_hold", 64);
        chk("wd_busy", 32'(busy), 32'd1);
        cyc(4);  chk_pwr("wd_down1", 32);
        cyc(4);  chk_pwr("wd_down0", 0);
        chk("wd_dead", 32'(state_dbg), 32'd1);

        // Emergency stop at 96
        do_reset();
        send(1'b0, 16'd0, 1'b1, 16'd100);
        cyc(3);  chk_pwr("es_p1", 32);
        cyc(8);  chk_pwr("es_p3", 96);
        estop = 1'b1;
        man_valid = 1'b1;
        man_power = 16'd500;
        cyc(1);
        chk_pwr("es_zero", 0);
        chk("es_state", 32'(state_dbg), 32'd2);
        chk("es_grant", 32'(grant), 32'd0);
        cyc(4);
        chk("es_hold_state", 32'(state_dbg), 32'd2);
        chk("es_hold_grant", 32'(grant), 32'd0);
        chk_pwr("es_hold_p", 0);
        estop = 1'b0;
        man_valid = 1'b0;
        cyc(1);  chk("es_rel_dead", 32'(state_dbg), 32'd1);
        cyc(9);  chk("es_dead_last", 32'(state_dbg), 32'd1);
        cyc(1);  chk("es_run", 32'(state_dbg), 32'd0);
        chk("es_run_busy", 32'(busy), 32'd0);
        cyc(4);  chk_pwr("es_run_p", 0);
        chk("es_run_grant", 32'(grant), 32'd0);

        // Asynchronous reset mid-ramp
        do_reset();
        send(1'b0, 16'd0, 1'b1, 16'd100);
        cyc(3);
        cyc(4);  chk_pwr("ar_p2", 64);
        #2;
        rst = 1'b1;
        #1;
        chk_pwr("ar_power", 0);
        chk("ar_grant", 32'(grant), 32'd0);
        chk("ar_state", 32'(state_dbg), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(8);
        chk_pwr("ar_after_p", 0);
        chk("ar_after_grant", 32'(grant), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
